// File: rtl/pkg_bdy_pwm.sv
// Shared definitions for the butterfly/PWM body and its upstream frame mux.
package pkg_bdy_pwm;

    localparam int unsigned PRM_DCOEF_DEF  = 32;
    localparam int unsigned PRM_DAXI_DEF   = 2 * PRM_DCOEF_DEF;
    localparam int unsigned PRM_COEFFS_DEF = 64;

    localparam logic [1:0] CTL_BUT_PWM  = 2'd0;
    localparam logic [1:0] CTL_BUT_NTT  = 2'd1;
    localparam logic [1:0] CTL_BUT_INTT = 2'd2;
    localparam logic [1:0] CTL_BUT_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_A = 2'd1,
        ST_SEND_B = 2'd2,
        ST_DRAIN  = 2'd3
    } fsmState_t;

endpackage

// File: rtl/mdl_axis_reg_slice.sv
// One-entry AXI-Stream output register; holds data/last stable while stalled.
module mdl_axis_reg_slice #(
    parameter int unsigned PRM_DW = 64
) (
    input  logic              iSYS_CLK,
    input  logic              iSYS_RST,
    input  logic              sValid,
    input  logic [PRM_DW-1:0] sData,
    input  logic              sLast,
    output logic              sReady_c,
    output logic              mValid,
    output logic [PRM_DW-1:0] mData,
    output logic              mLast,
    input  logic              mReady
);

    assign sReady_c = !mValid || mReady;

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            mValid <= 1'b0;
            mData  <= '0;
            mLast  <= 1'b0;
        end else if (sReady_c) begin
            mValid <= sValid;
            if (sValid) begin
                mData <= sData;
                mLast <= sLast;
            end
        end
    end

endmodule

// File: rtl/mdl_bdy_pwm_frame_mux.sv
// Merges operand A (coefficient pairs) and operand B (PWM coefficients) into
// one 64-bit frame stream for the body, with start/done and framing checks.
module mdl_bdy_pwm_frame_mux
    import pkg_bdy_pwm::*;
#(
    parameter int unsigned PRM_DAXI   = PRM_DAXI_DEF,
    parameter int unsigned PRM_DCOEF  = PRM_DCOEF_DEF,
    parameter int unsigned PRM_COEFFS = PRM_COEFFS_DEF
) (
    input  logic                 iSYS_CLK,
    input  logic                 iSYS_RST,
    input  logic                 iCMD_START,
    input  logic [1:0]           iCMD_BUT,
    input  logic [1:0]           iCMD_Q,
    output logic [1:0]           oCTL_BUT,
    output logic [1:0]           oCTL_Q,
    output logic                 oFSM_START,
    output logic                 oBUSY,
    output logic                 oDONE,
    output logic                 oERR,
    input  logic                 iA_Tvalid,
    output logic                 oA_Tready,
    input  logic [PRM_DAXI-1:0]  iA_Tdata,
    input  logic                 iA_Tlast,
    input  logic                 iB_Tvalid,
    output logic                 oB_Tready,
    input  logic [PRM_DCOEF-1:0] iB_Tdata,
    input  logic                 iB_Tlast,
    output logic                 oWs_Tvalid,
    input  logic                 iWs_Tready,
    output logic [PRM_DAXI-1:0]  oWs_Tdata,
    output logic                 oWs_Tlast
);

    localparam int unsigned      CNT_W  = $clog2(PRM_COEFFS) + 1;
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(PRM_COEFFS / 2 - 1);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(PRM_COEFFS - 1);

    fsmState_t        state, stateNext;
    logic [CNT_W-1:0] beatCnt, beatCntNext;
    logic [1:0]       ctlBut, ctlButNext, ctlQ, ctlQNext;
    logic             fsmStart, fsmStartNext;
    logic             busy, busyNext;
    logic             done, doneNext;
    logic             err, errNext;

    logic                sliceReady_c;
    logic                aFire_c, bFire_c, aLastBeat_c, bLastBeat_c;
    logic                sValid_c, sLast_c;
    logic [PRM_DAXI-1:0] sData_c;

    assign oA_Tready   = (state == ST_SEND_A) && sliceReady_c;
    assign oB_Tready   = (state == ST_SEND_B) && sliceReady_c;
    assign aFire_c     = iA_Tvalid && oA_Tready;
    assign bFire_c     = iB_Tvalid && oB_Tready;
    assign aLastBeat_c = (beatCnt == A_LAST);
    assign bLastBeat_c = (beatCnt == B_LAST);

    // Frame payload: A passes through, B is zero-extended into the low half
    assign sValid_c = aFire_c || bFire_c;
    assign sData_c  = (state == ST_SEND_B) ? PRM_DAXI'(iB_Tdata) : iA_Tdata;
    assign sLast_c  = (state == ST_SEND_B) ? bLastBeat_c
                                           : (aLastBeat_c && (ctlBut != CTL_BUT_PWM));

    mdl_axis_reg_slice #(.PRM_DW(PRM_DAXI)) uOutReg (
        .iSYS_CLK (iSYS_CLK),
        .iSYS_RST (iSYS_RST),
        .sValid   (sValid_c),
        .sData    (sData_c),
        .sLast    (sLast_c),
        .sReady_c (sliceReady_c),
        .mValid   (oWs_Tvalid),
        .mData    (oWs_Tdata),
        .mLast    (oWs_Tlast),
        .mReady   (iWs_Tready)
    );

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            state    <= ST_IDLE;
            beatCnt  <= '0;
            ctlBut   <= 2'd0;
            ctlQ     <= 2'd0;
            fsmStart <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= stateNext;
            beatCnt  <= beatCntNext;
            ctlBut   <= ctlButNext;
            ctlQ     <= ctlQNext;
            fsmStart <= fsmStartNext;
            busy     <= busyNext;
            done     <= doneNext;
            err      <= errNext;
        end
    end

    // Framing is purely count-based; source Tlast only feeds the error flag
    always_comb begin
        stateNext    = state;
        beatCntNext  = beatCnt;
        ctlButNext   = ctlBut;
        ctlQNext     = ctlQ;
        fsmStartNext = 1'b0;
        doneNext     = 1'b0;
        errNext      = err;
        unique case (state)
            ST_IDLE: begin
                if (iCMD_START) begin
                    if (iCMD_BUT == CTL_BUT_RSVD) begin
                        errNext  = 1'b1;
                        doneNext = 1'b1;
                    end else begin
                        stateNext    = ST_SEND_A;
                        ctlButNext   = iCMD_BUT;
                        ctlQNext     = iCMD_Q;
                        errNext      = 1'b0;
                        beatCntNext  = '0;
                        fsmStartNext = 1'b1;
                    end
                end
            end
            ST_SEND_A: begin
                if (aFire_c) begin
                    if (iA_Tlast != aLastBeat_c) errNext = 1'b1;
                    if (aLastBeat_c) begin
                        beatCntNext = '0;
                        stateNext   = (ctlBut == CTL_BUT_PWM) ? ST_SEND_B : ST_DRAIN;
                    end else begin
                        beatCntNext = beatCnt + CNT_W'(1);
                    end
                end
            end
            ST_SEND_B: begin
                if (bFire_c) begin
                    if (iB_Tlast != bLastBeat_c) errNext = 1'b1;
                    if (bLastBeat_c) begin
                        beatCntNext = '0;
                        stateNext   = ST_DRAIN;
                    end else begin
                        beatCntNext = beatCnt + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (oWs_Tvalid && iWs_Tready) begin
                    stateNext = ST_IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    assign busyNext   = (stateNext != ST_IDLE);
    assign oCTL_BUT   = ctlBut;
    assign oCTL_Q     = ctlQ;
    assign oFSM_START = fsmStart;
    assign oBUSY      = busy;
    assign oDONE      = done;
    assign oERR       = err;

endmodule

// File: tb/tb_mdl_bdy_pwm_frame_mux.sv
// Directed bench for the frame mux: PWM/NTT frames, backpressure, framing
// errors, start corner cases and mid-frame reset.
module tb_mdl_bdy_pwm_frame_mux;
    import pkg_bdy_pwm::*;

    localparam int unsigned DAXI   = 64;
    localparam int unsigned DCOEF  = 32;
    localparam int unsigned COEFFS = 64;
    localparam int          NA     = COEFFS / 2;
    localparam int          NB     = COEFFS;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             iCMD_START = 1'b0;
    logic [1:0]       iCMD_BUT = 2'd0, iCMD_Q = 2'd0;
    logic [1:0]       oCTL_BUT, oCTL_Q;
    logic             oFSM_START, oBUSY, oDONE, oERR;
    logic             iA_Tvalid = 1'b0, oA_Tready, iA_Tlast = 1'b0;
    logic [DAXI-1:0]  iA_Tdata = '0;
    logic             iB_Tvalid = 1'b0, oB_Tready, iB_Tlast = 1'b0;
    logic [DCOEF-1:0] iB_Tdata = '0;
    logic             oWs_Tvalid, oWs_Tlast;
    logic             wsReady = 1'b1;
    logic [DAXI-1:0]  oWs_Tdata;

    always #5 clk = ~clk;

    mdl_bdy_pwm_frame_mux #(.PRM_DAXI(DAXI), .PRM_DCOEF(DCOEF), .PRM_COEFFS(COEFFS)) dut (
        .iSYS_CLK(clk), .iSYS_RST(rstN),
        .iCMD_START(iCMD_START), .iCMD_BUT(iCMD_BUT), .iCMD_Q(iCMD_Q),
        .oCTL_BUT(oCTL_BUT), .oCTL_Q(oCTL_Q), .oFSM_START(oFSM_START),
        .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR),
        .iA_Tvalid(iA_Tvalid), .oA_Tready(oA_Tready), .iA_Tdata(iA_Tdata), .iA_Tlast(iA_Tlast),
        .iB_Tvalid(iB_Tvalid), .oB_Tready(oB_Tready), .iB_Tdata(iB_Tdata), .iB_Tlast(iB_Tlast),
        .oWs_Tvalid(oWs_Tvalid), .iWs_Tready(wsReady), .oWs_Tdata(oWs_Tdata), .oWs_Tlast(oWs_Tlast)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] outVec();
        return 96'({oWs_Tvalid, oWs_Tdata, oWs_Tlast, oA_Tready, oB_Tready, oFSM_START,
                    oDONE, oBUSY, oERR, oCTL_BUT, oCTL_Q});
    endfunction

    // Downstream ready: constant 1, or the repeating 1,0,0,1 pattern
    logic bpOn = 1'b0;
    int   bpPh = 0;
    always @(negedge clk) begin
        bpPh    <= (bpPh + 1) % 4;
        wsReady <= !bpOn || bpPh == 0 || bpPh == 3;
    end

    // Output monitor: accepted beats, done timing, stall stability
    logic [DAXI-1:0] beatData[$];
    logic            beatLast[$];
    int              cyc = 0, lastHsCyc = -10, doneCyc = -20;
    int              doneCnt = 0, startCnt = 0, bReadyCnt = 0, stabErr = 0;
    logic            busyAtDone = 1'b1;
    logic            prevStall = 1'b0, prevLast = 1'b0;
    logic [DAXI-1:0] prevData = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstN) begin
            if (oWs_Tvalid && wsReady) begin
                beatData.push_back(oWs_Tdata);
                beatLast.push_back(oWs_Tlast);
                if (oWs_Tlast) lastHsCyc <= cyc;
            end
            if (prevStall && (!oWs_Tvalid || oWs_Tdata !== prevData || oWs_Tlast !== prevLast))
                stabErr <= stabErr + 1;
            prevStall <= oWs_Tvalid && !wsReady;
            prevData  <= oWs_Tdata;
            prevLast  <= oWs_Tlast;
            if (oDONE) begin
                doneCnt    <= doneCnt + 1;
                doneCyc    <= cyc;
                busyAtDone <= oBUSY;
            end
            if (oFSM_START) startCnt <= startCnt + 1;
            if (oB_Tready) bReadyCnt <= bReadyCnt + 1;
        end else begin
            prevStall <= 1'b0;
        end
    end

    task automatic startCmd(input logic [1:0] but, input logic [1:0] q);
        @(negedge clk);
        iCMD_START = 1'b1;
        iCMD_BUT   = but;
        iCMD_Q     = q;
        @(negedge clk);
        iCMD_START = 1'b0;
    endtask

    // Drives A then B beats; stops early after abortAt accepted beats when nonzero
    task automatic runFrame(input int nA, input int nB, input int errA, input bit errB,
                            input int busyStartAt, input int abortAt);
        int idx = 0;
        int guard = 0;
        int total = nA + nB;
        int k;
        bit sent = 1'b0;
        while (idx < total && (abortAt == 0 || idx < abortAt) && guard < 2000) begin
            @(negedge clk);
            guard++;
            k = idx + 1;
            iCMD_START = 1'b0;
            if (!sent && k == busyStartAt) begin
                iCMD_START = 1'b1;
                iCMD_BUT   = CTL_BUT_NTT;
                sent       = 1'b1;
            end
            if (idx < nA) begin
                iA_Tvalid = 1'b1;
                iA_Tdata  = {DCOEF'(k), DCOEF'(k)};
                iA_Tlast  = (k == nA) != (k == errA);
                iB_Tvalid = 1'b0;
            end else begin
                iA_Tvalid = 1'b0;
                iB_Tvalid = 1'b1;
                iB_Tdata  = DCOEF'(k);
                iB_Tlast  = (k == total) && !errB;
            end
            #1;
            if ((idx < nA) ? oA_Tready : oB_Tready) idx++;
        end
        check("src_beats_accepted", 96'(idx), 96'((abortAt != 0) ? abortAt : total));
        @(negedge clk);
        iA_Tvalid  = 1'b0;
        iB_Tvalid  = 1'b0;
        iCMD_START = 1'b0;
    endtask

    task automatic waitDone(input int target, input string tag);
        int g = 0;
        while (doneCnt < target && g < 600) begin
            @(negedge clk);
            g++;
        end
        check(tag, 96'(doneCnt), 96'(target));
    endtask

    task automatic checkBeats(input string tag, input int base, input int nA, input int total);
        int bad = 0;
        logic [DAXI-1:0] expd;
        check({tag, "_count"}, 96'(beatData.size() - base), 96'(total));
        for (int i = 0; i < total && base + i < beatData.size(); i++) begin
            expd = (i + 1 <= nA) ? {DCOEF'(i + 1), DCOEF'(i + 1)} : {DCOEF'(0), DCOEF'(i + 1)};
            if (beatData[base + i] !== expd || beatLast[base + i] !== (i == total - 1)) bad++;
        end
        check({tag, "_order"}, 96'(bad), 96'(0));
    endtask

    initial begin
        int base;
        int s0;
        int b0;
        int dn;

        #12;
        check("reset_outputs", outVec(), 96'(0));
        @(negedge clk);
        rstN = 1'b1;

        // PWM frame, no backpressure
        base = beatData.size();
        startCmd(CTL_BUT_PWM, 2'd1);
        check("pwm_fsm_start", 96'(oFSM_START), 96'(1));
        check("pwm_first_no_beat", 96'(oWs_Tvalid), 96'(0));
        check("pwm_busy", 96'(oBUSY), 96'(1));
        runFrame(NA, NB, 0, 1'b0, 0, 0);
        waitDone(1, "pwm_done");
        checkBeats("pwm", base, NA, NA + NB);
        check("pwm_done_latency", 96'(doneCyc - lastHsCyc), 96'(1));
        check("pwm_busy_at_done", 96'(busyAtDone), 96'(0));
        check("pwm_err", 96'(oERR), 96'(0));
        check("pwm_start_pulses", 96'(startCnt), 96'(1));
        check("pwm_ctl_q", 96'(oCTL_Q), 96'(1));

        // NTT frame: A only, B never ready
        base = beatData.size();
        b0   = bReadyCnt;
        startCmd(CTL_BUT_NTT, 2'd2);
        runFrame(NA, 0, 0, 1'b0, 0, 0);
        waitDone(2, "ntt_done");
        checkBeats("ntt", base, NA, NA);
        check("ntt_b_ready", 96'(bReadyCnt - b0), 96'(0));
        repeat (3) @(negedge clk);
        check("ntt_ctl_but_hold", 96'(oCTL_BUT), 96'(1));
        check("ntt_ctl_q", 96'(oCTL_Q), 96'(2));

        // PWM with downstream backpressure 1,0,0,1
        base = beatData.size();
        bpOn = 1'b1;
        startCmd(CTL_BUT_PWM, 2'd0);
        check("bp_ctl_but", 96'(oCTL_BUT), 96'(0));
        runFrame(NA, NB, 0, 1'b0, 0, 0);
        waitDone(3, "bp_done");
        bpOn = 1'b0;
        checkBeats("bp", base, NA, NA + NB);
        check("bp_stable", 96'(stabErr), 96'(0));
        check("bp_done_latency", 96'(doneCyc - lastHsCyc), 96'(1));

        // A Tlast asserted early on beat 5
        base = beatData.size();
        startCmd(CTL_BUT_PWM, 2'd0);
        runFrame(NA, NB, 5, 1'b0, 0, 0);
        check("alast_err_pre_done", 96'(oERR), 96'(1));
        waitDone(4, "alast_done");
        checkBeats("alast", base, NA, NA + NB);
        repeat (3) @(negedge clk);
        check("alast_err_hold", 96'(oERR), 96'(1));

        // Next start clears the error; B Tlast missing on final beat sets it
        startCmd(CTL_BUT_PWM, 2'd0);
        check("blast_err_cleared", 96'(oERR), 96'(0));
        runFrame(NA, NB, 0, 1'b1, 0, 0);
        waitDone(5, "blast_done");
        check("blast_err", 96'(oERR), 96'(1));

        // Start while busy is ignored
        base = beatData.size();
        s0   = startCnt;
        iCMD_BUT = CTL_BUT_PWM;
        startCmd(CTL_BUT_PWM, 2'd1);
        runFrame(NA, NB, 0, 1'b0, 20, 0);
        waitDone(6, "busystart_done");
        checkBeats("busystart", base, NA, NA + NB);
        check("busystart_ctl_but", 96'(oCTL_BUT), 96'(0));
        check("busystart_pulses", 96'(startCnt - s0), 96'(1));
        check("busystart_err", 96'(oERR), 96'(0));

        // Reserved mode: immediate done with error and no beats
        base = beatData.size();
        startCmd(CTL_BUT_RSVD, 2'd0);
        check("rsvd_done", 96'(oDONE), 96'(1));
        check("rsvd_err", 96'(oERR), 96'(1));
        check("rsvd_busy", 96'(oBUSY), 96'(0));
        check("rsvd_fsm_start", 96'(oFSM_START), 96'(0));
        repeat (4) @(negedge clk);
        check("rsvd_no_beats", 96'(beatData.size() - base), 96'(0));
        check("rsvd_done_pulses", 96'(doneCnt), 96'(7));

        // Reset after 10 beats aborts the frame
        startCmd(CTL_BUT_PWM, 2'd3);
        runFrame(NA, NB, 0, 1'b0, 0, 10);
        rstN = 1'b0;
        #1;
        check("midrst_outputs", outVec(), 96'(0));
        @(negedge clk);
        rstN = 1'b1;
        dn   = doneCnt;
        base = beatData.size();
        startCmd(CTL_BUT_PWM, 2'd0);
        runFrame(NA, NB, 0, 1'b0, 0, 0);
        waitDone(dn + 1, "postrst_done");
        checkBeats("postrst", base, NA, NA + NB);
        check("postrst_err", 96'(oERR), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdl_bdy_pwm_frame_mux.md
# mdl_bdy_pwm_frame_mux

Upstream framer for the butterfly/PWM body. It merges two independent AXI-Stream sources into the single 64-bit input frame the body consumes:
- Operand A: packed coefficient pairs.
- Operand B: one coefficient per beat, PWM only.

It also issues the body's start pulse and latches the mode/modulus controls for the duration of one frame.

## Interface
Parameters:
- PRM_DAXI, 64, frame stream data width
- PRM_DCOEF, 32, coefficient width; PRM_DAXI = 2*PRM_DCOEF
- PRM_COEFFS, 64, coefficients per polynomial; power of two, ≥ 4

Ports:
- iSYS_CLK  in  1  system clock; every flop is clocked on its rising edge
- iSYS_RST  in  1  reset, asynchronous, active-low
- iCMD_START  in  1  start request; sampled only in IDLE
- iCMD_BUT  in  2  mode: 0 PWM, 1 NTT, 2 INTT, 3 reserved
- iCMD_Q  in  2  modulus select, latched at start
- oCTL_BUT  out  2  latched mode, to body
- oCTL_Q  out  2  latched modulus, to body
- oFSM_START  out  1  one-cycle start pulse, to body
- oBUSY  out  1  high whenever the FSM is not in IDLE
- oDONE  out  1  one-cycle pulse when the frame completes
- oERR  out  1  sticky framing error; cleared by the next accepted start
- iA_Tvalid / oA_Tready / iA_Tdata[PRM_DAXI-1:0] / iA_Tlast  operand A stream
  - Low half carries the even-index coefficient; high half carries the odd-index coefficient.
- iB_Tvalid / oB_Tready / iB_Tdata[PRM_DCOEF-1:0] / iB_Tlast  operand B stream
- oWs_Tvalid / iWs_Tready / oWs_Tdata[PRM_DAXI-1:0] / oWs_Tlast  frame stream to body

## Operation
- FSM states: IDLE, SEND_A, SEND_B, DRAIN.
- IDLE → SEND_A
  - Condition: iCMD_START=1 and iCMD_BUT≠3.
  - Latches iCMD_BUT and iCMD_Q, clears oERR, clears the beat counter, and pulses oFSM_START.
- iCMD_START with iCMD_BUT=3: stay in IDLE, set oERR, pulse oDONE; no beats are emitted.
- SEND_A
  - Forwards iA_Tdata unchanged.
  - After PRM_COEFFS/2 accepted A beats: go to SEND_B if the latched mode is PWM, otherwise go to DRAIN.
- SEND_B
  - Forwards {PRM_DCOEF'b0, iB_Tdata}.
  - After PRM_COEFFS accepted B beats: go to DRAIN.
- DRAIN: waits for the last output beat to be accepted downstream, then pulses oDONE and returns to IDLE.
- oWs_Tlast
  - PWM: set on the final B beat (beat number 3·PRM_COEFFS/2 of the frame).
  - NTT/INTT: set on A beat number PRM_COEFFS/2.
- Source Tlast check
  - oERR is set if a source's Tlast is high on any beat other than that source's last beat, or low on its last beat.
  - Framing is always count-based; the check never truncates or extends a frame.
- The beat counter is clog2(PRM_COEFFS)+1 bits wide and is cleared on each phase change.
- The inactive source always sees Tready=0.
- iCMD_START while oBUSY=1 is ignored.

## Timing
- Output register: one entry.
  - Source Tready = (state matches source) && (!oWs_Tvalid || iWs_Tready).
  - A source beat accepted in cycle n is presented on oWs in cycle n+1.
  - Full throughput is one beat per cycle with no bubbles at the A→B boundary.
- Output data stability: oWs_Tdata and oWs_Tlast stay stable while oWs_Tvalid=1 and iWs_Tready=0.
- oFSM_START is asserted in the cycle after iCMD_START is sampled, i.e. the first cycle in SEND_A. The first oWs beat appears no earlier than the following cycle.
- oDONE is asserted in the cycle after the oWs_Tlast handshake. oBUSY falls in that same cycle.
- Reset: asynchronous, active-low; a mid-frame reset aborts the frame.
  - State returns to IDLE; the counter and output register are cleared.
  - All outputs go to 0: oWs_Tvalid, oWs_Tdata, oWs_Tlast, oA_Tready, oB_Tready, oFSM_START, oDONE, oBUSY, oERR, oCTL_BUT, oCTL_Q.

## Structure
- Package pkg_bdy_pwm holds:
  - Mode constants CTL_BUT_PWM=0, CTL_BUT_NTT=1, CTL_BUT_INTT=2.
  - The FSM state encoding.
  - Width parameters shared with the body.
- Sub-module: mdl_axis_reg_slice, the one-entry output register with valid/ready/data/last.

## Test plan
- PWM, PRM_COEFFS=64, iWs_Tready=1
  - A beats k=1..32: data {k,k}. B beats k=33..96: data k.
  - Expect 96 output beats: {k,k} then {32'd0,k}. Tlast only on beat 96. oDONE one cycle later. oERR=0.
- NTT mode, 32 A beats
  - Expect 32 beats with Tlast on beat 32.
  - oB_Tready stays 0 throughout.
  - oCTL_BUT=1 holds until the next start.
- Backpressure: iWs_Tready toggles 1,0,0,1 during PWM.
  - No beat is lost or duplicated.
  - Data is stable while stalled.
  - Beat order matches the first scenario.
- Tlast errors
  - iA_Tlast high on A beat 5: oERR=1, the frame still emits 96 beats, and oERR holds through oDONE until the next start.
  - iB_Tlast low on the final B beat: oERR=1.
- Start edge cases
  - iCMD_BUT=3: oDONE pulses with no output beats and oERR=1.
  - iCMD_START while busy: ignored; the frame is unchanged.
- Reset mid-frame: drive iSYS_RST=0 after 10 beats.
  - All outputs are 0 immediately.
  - A subsequent PWM start produces a correct complete 96-beat frame.
